// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg: shared constants, types and helpers for the ALU serial link.
//   PKT_BITS / DATA_PKTS   : packet length and data packets per valid result
//   TYPE_DATA / TYPE_CTL   : packet type bit values
//   CTL_ERR_BIT            : error flag position inside the control byte
//   CTL_ERR_DEFAULT        : control byte the ALU reports for an error
//   state_e                : serializer frame state
//   pkt_word(), last_pkt() : {type, byte} of a packet and last packet index

package mtm_alu_pkg;

    localparam int unsigned PKT_BITS        = 11;
    localparam int unsigned DATA_PKTS       = 4;
    localparam logic        TYPE_DATA       = 1'b0;
    localparam logic        TYPE_CTL        = 1'b1;
    localparam int unsigned CTL_ERR_BIT     = 7;
    localparam logic [7:0]  CTL_ERR_DEFAULT = 8'b1001_0011;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_e;

    // {type, byte} for packet idx of a frame. An error frame carries only the
    // control byte, so every index maps to it.
    function automatic logic [8:0] pkt_word(input logic [31:0] c,
                                            input logic [7:0]  ctl,
                                            input logic [2:0]  idx);
        logic [8:0] w;
        w = {TYPE_CTL, ctl};
        if (!ctl[CTL_ERR_BIT]) begin
            case (idx)
                3'd0:    w = {TYPE_DATA, c[31:24]};
                3'd1:    w = {TYPE_DATA, c[23:16]};
                3'd2:    w = {TYPE_DATA, c[15:8]};
                3'd3:    w = {TYPE_DATA, c[7:0]};
                default: w = {TYPE_CTL, ctl};
            endcase
        end
        return w;
    endfunction

    // Index of the final (control) packet of a frame.
    function automatic logic [2:0] last_pkt(input logic [7:0] ctl);
        return ctl[CTL_ERR_BIT] ? 3'd0 : 3'(DATA_PKTS);
    endfunction

endpackage

// File: rtl/mtm_alu_packet_tx.sv
// mtm_alu_packet_tx: shifts one 11-bit packet {start 0, type, D7..D0, stop 1}
// onto the serial line, MSB (start bit) first, one bit per clock.
//   clk        : system clock
//   rst_n      : synchronous active-low reset; line returns to idle high
//   i_load     : load a new packet; its start bit is driven after this edge
//   i_type     : packet type bit
//   i_byte     : packet payload
//   o_sout     : registered serial output, idle high
//   o_last_bit : high while the stop bit of the current packet is driven

module mtm_alu_packet_tx
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_type,
    input  logic [7:0] i_byte,
    output logic       o_sout,
    output logic       o_last_bit
);

    logic [10:0] r_shift;
    logic [3:0]  r_bit;
    logic        r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '1;
            r_bit   <= 4'd0;
            r_busy  <= 1'b0;
        end else if (i_load) begin
            r_shift <= {1'b0, i_type, i_byte, 1'b1};
            r_bit   <= 4'd0;
            r_busy  <= 1'b1;
        end else begin
            // Shift in ones so the line idles high once the stop bit is out.
            r_shift <= {r_shift[9:0], 1'b1};
            if (r_busy) begin
                if (o_last_bit) begin
                    r_bit  <= 4'd0;
                    r_busy <= 1'b0;
                end else begin
                    r_bit <= r_bit + 4'd1;
                end
            end
        end
    end

    assign o_sout     = r_shift[10];
    assign o_last_bit = r_busy && (r_bit == 4'(PKT_BITS - 1));

endmodule

// File: rtl/mtm_alu_serializer.sv
// mtm_alu_serializer: transmit end of the ALU serial link. Captures one result
// (C, CTL) and sends it as 4 data packets + 1 control packet, or as a single
// control packet when CTL bit 7 flags an error, followed by GAP_BITS idle bits.
//   clk        : system clock, one serial bit per cycle
//   rst_n      : synchronous active-low reset
//   res_valid  : result present on res_c / res_ctl
//   res_c      : ALU result word
//   res_ctl    : ALU control byte, bit 7 = error
//   ready      : a result is accepted this cycle if res_valid is high
//   sout       : serial line, idle high
//   frame_done : high while the final stop bit of a frame is driven

module mtm_alu_serializer
    import mtm_alu_pkg::*;
#(
    parameter int unsigned GAP_BITS = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        res_valid,
    input  logic [31:0] res_c,
    input  logic [7:0]  res_ctl,
    output logic        ready,
    output logic        sout,
    output logic        frame_done
);

    state_e      r_state, w_state_d;
    logic [31:0] r_c;
    logic [7:0]  r_ctl;
    logic [2:0]  r_pkt, w_pkt_d;
    logic [3:0]  r_gap, w_gap_d;
    logic        w_accept;
    logic        w_load;
    logic [8:0]  w_word;
    logic        w_last_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_c     <= 32'd0;
            r_ctl   <= 8'd0;
            r_pkt   <= 3'd0;
            r_gap   <= 4'd0;
        end else begin
            r_state <= w_state_d;
            r_pkt   <= w_pkt_d;
            r_gap   <= w_gap_d;
            if (w_accept) begin
                r_c   <= res_c;
                r_ctl <= res_ctl;
            end
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_pkt_d    = r_pkt;
        w_gap_d    = r_gap;
        w_load     = 1'b0;
        w_word     = pkt_word(res_c, res_ctl, 3'd0);
        ready      = 1'b0;
        frame_done = 1'b0;

        unique case (r_state)
            IDLE: begin
                ready = 1'b1;
            end
            SEND: begin
                if (w_last_bit) begin
                    if (r_pkt != last_pkt(r_ctl)) begin
                        // Next packet's start bit follows this stop bit directly.
                        w_pkt_d = r_pkt + 3'd1;
                        w_load  = 1'b1;
                        w_word  = pkt_word(r_c, r_ctl, r_pkt + 3'd1);
                    end else begin
                        frame_done = 1'b1;
                        w_pkt_d    = 3'd0;
                        if (GAP_BITS > 0) begin
                            w_state_d = GAP;
                            w_gap_d   = 4'(GAP_BITS);
                        end else begin
                            ready     = 1'b1;
                            w_state_d = IDLE;
                        end
                    end
                end
            end
            GAP: begin
                if (r_gap == 4'd1) begin
                    ready     = 1'b1;
                    w_state_d = IDLE;
                    w_gap_d   = 4'd0;
                end else begin
                    w_gap_d = r_gap - 4'd1;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // An accept overrides whatever the state would otherwise do next.
        w_accept = res_valid && ready;
        if (w_accept) begin
            w_state_d = SEND;
            w_pkt_d   = 3'd0;
            w_gap_d   = 4'd0;
            w_load    = 1'b1;
            w_word    = pkt_word(res_c, res_ctl, 3'd0);
        end
    end

    mtm_alu_packet_tx u_packet_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_type     (w_word[8]),
        .i_byte     (w_word[7:0]),
        .o_sout     (sout),
        .o_last_bit (w_last_bit)
    );

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Bench for mtm_alu_serializer: two instances (GAP_BITS 0 and 3) driven from
// directed and random results. Expected line activity is queued per accepted
// result and compared cycle by cycle against sout, frame_done and ready.

module tb_mtm_alu_serializer;
    import mtm_alu_pkg::*;

    typedef struct packed {
        logic sout;
        logic fd;
        logic rdy;
    } ent_t;

    localparam ent_t IDLE_ENT = '{sout: 1'b1, fd: 1'b0, rdy: 1'b1};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rv0   = 1'b0;
    logic        rv1   = 1'b0;
    logic [31:0] c0    = 32'd0;
    logic [31:0] c1    = 32'd0;
    logic [7:0]  ctl0  = 8'd0;
    logic [7:0]  ctl1  = 8'd0;
    logic        rdy0, sout0, fd0;
    logic        rdy1, sout1, fd1;

    ent_t q0[$];
    ent_t q1[$];
    logic rdy_exp0 = 1'b0;
    logic rdy_exp1 = 1'b0;
    bit   mon_en   = 1'b0;
    int   acc0     = 0;
    int   acc1     = 0;
    int   checks   = 0;
    int   errors   = 0;

    always #5 clk = ~clk;

    mtm_alu_serializer #(.GAP_BITS(0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_valid  (rv0),
        .res_c      (c0),
        .res_ctl    (ctl0),
        .ready      (rdy0),
        .sout       (sout0),
        .frame_done (fd0)
    );

    mtm_alu_serializer #(.GAP_BITS(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_valid  (rv1),
        .res_c      (c1),
        .res_ctl    (ctl1),
        .ready      (rdy1),
        .sout       (sout1),
        .frame_done (fd1)
    );

    task automatic push_ent(input int ch, input ent_t e);
        if (ch == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    // Expected line for one accepted result, one entry per future clock cycle.
    task automatic push_frame(input int ch, input logic [31:0] c, input logic [7:0] ctl);
        logic [8:0]  pkts[$];
        logic [10:0] bits;
        int          gap;
        int          total;
        int          idx;
        ent_t        e;
        gap = (ch == 0) ? 0 : 3;
        if (ctl[7] == 1'b0) begin
            for (int i = 3; i >= 0; i--) pkts.push_back({1'b0, c[8*i +: 8]});
        end
        pkts.push_back({1'b1, ctl});
        total = 11 * pkts.size();
        idx   = 0;
        foreach (pkts[p]) begin
            bits = {1'b0, pkts[p], 1'b1};
            for (int b = 10; b >= 0; b--) begin
                e.sout = bits[b];
                e.fd   = (idx == total - 1);
                e.rdy  = (gap == 0) && (idx == total - 1);
                push_ent(ch, e);
                idx++;
            end
        end
        for (int j = 0; j < gap; j++) begin
            e.sout = 1'b1;
            e.fd   = 1'b0;
            e.rdy  = (j == gap - 1);
            push_ent(ch, e);
        end
    endtask

    task automatic check(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    // Reference model: decides accepts from its own ready and queues frames.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                q0.delete();
                q1.delete();
                mon_en = 1'b1;
            end else begin
                if (rv0 && rdy_exp0) begin
                    push_frame(0, c0, ctl0);
                    acc0++;
                end
                if (rv1 && rdy_exp1) begin
                    push_frame(1, c1, ctl1);
                    acc1++;
                end
            end
        end
    end

    // Monitor: pops the expected entry for this cycle and compares.
    initial begin
        ent_t e0;
        ent_t e1;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (q0.size() > 0) e0 = q0.pop_front();
                else               e0 = IDLE_ENT;
                if (q1.size() > 0) e1 = q1.pop_front();
                else               e1 = IDLE_ENT;
                check("g0_sout",       sout0, e0.sout);
                check("g0_frame_done", fd0,   e0.fd);
                check("g0_ready",      rdy0,  e0.rdy);
                check("g3_sout",       sout1, e1.sout);
                check("g3_frame_done", fd1,   e1.fd);
                check("g3_ready",      rdy1,  e1.rdy);
                rdy_exp0 = e0.rdy;
                rdy_exp1 = e1.rdy;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drive(input int ch, input logic v, input logic [31:0] c, input logic [7:0] ctl);
        if (ch == 0) begin
            rv0 = v; c0 = c; ctl0 = ctl;
        end else begin
            rv1 = v; c1 = c; ctl1 = ctl;
        end
    endtask

    // Present a result and hold it until the model has accepted it.
    task automatic send(input int ch, input logic [31:0] c, input logic [7:0] ctl);
        int start;
        bit got;
        start = (ch == 0) ? acc0 : acc1;
        got   = 1'b0;
        drive(ch, 1'b1, c, ctl);
        for (int i = 0; i < 120 && !got; i++) begin
            @(negedge clk);
            #1;
            got = (((ch == 0) ? acc0 : acc1) != start);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout ch%0d: accepted 0 expected 1", ch);
        end
    endtask

    initial begin
        logic [31:0] rc;
        logic [7:0]  rctl;

        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Data frame, with an ignored pulse and input changes mid-frame;
        // error frame on the gapped instance at the same time.
        send(0, 32'h1234_5678, 8'h36);
        drive(0, 1'b0, 32'h1234_5678, 8'h36);
        send(1, 32'hFFFF_FFFF, CTL_ERR_DEFAULT);
        drive(1, 1'b0, 32'h0, 8'h00);
        idle(9);
        drive(0, 1'b1, 32'h0, 8'h00);
        idle(1);
        drive(0, 1'b0, 32'hDEAD_BEEF, 8'hAA);
        idle(60);

        // Back-to-back frames with res_valid held high.
        send(0, 32'hA5A5_0F0F, 8'h12);
        send(0, 32'h0123_4567, 8'h7E);
        drive(0, 1'b0, 32'h0, 8'h00);
        send(1, 32'hCAFE_F00D, 8'h21);
        send(1, 32'h8001_0203, 8'h44);
        drive(1, 1'b0, 32'h0, 8'h00);
        idle(80);

        // Random results, back-to-back, roughly one in three flagged as errors.
        for (int ch = 0; ch < 2; ch++) begin
            for (int i = 0; i < 5; i++) begin
                rc      = $urandom;
                rctl    = 8'($urandom);
                rctl[7] = ($urandom_range(0, 2) == 0);
                send(ch, rc, rctl);
            end
            drive(ch, 1'b0, 32'h0, 8'h00);
            idle(70);
        end

        // One-cycle reset in the middle of a data frame, then a clean frame.
        send(0, $urandom, 8'h05);
        drive(0, 1'b0, 32'h0, 8'h00);
        idle(19);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(2);
        send(0, 32'h55AA_33CC, 8'h0F);
        drive(0, 1'b0, 32'h0, 8'h00);
        idle(70);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
